waymask_applier: RTL and testbench
==================================

# waymask_applier

Consumer side of the automatic cache-partitioning suggestion path. Takes the thermometer-coded waymask suggestions produced by the hit-counter/partition monitor and filters them with hysteresis. It then walks the cache's active waymask toward the accepted target one way at a time. Before any way is removed from the mask, it hands that way to the cache's flush engine and waits for completion.

## Interface
- CACHE_ASSOCIATIVITY, 16: number of ways; only 16 is supported.
- STABLE_COUNT, 2: number of consecutive identical valid suggestions required before a target is accepted (1..15).
- clk_in  input  1  single clock; all state is updated on the rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- suggest_valid_in  input  1  one-cycle pulse; suggested_waymask_in is valid in that cycle.
- suggested_waymask_in  input  16  suggestion; legal values are thermometer codes with bit 0 set (0x0001, 0x0003, ... 0xFFFF).
- flush_ack_in  input  1  flush engine has finished cleaning flush_way_out.
- flush_req_out  output  1  request to flush/invalidate one way.
- flush_way_out  output  4  index of the way to flush; stable while flush_req_out is high.
- active_waymask_out  output  16  waymask applied to the cache allocation logic.
- busy_out  output  1  FSM is not in IDLE.
- error_out  output  1  sticky flag: an illegal suggestion was seen.

## Operation
- Decode: a legal mask maps to a way count N = popcount, 1..16. A mask that is illegal (zero, or not a thermometer code) has these effects:
  - error_out is set.
  - The suggestion is dropped.
  - The stability counter is cleared.
- Filter: the block keeps a candidate count C and a stability counter S (4 bits).
  - A legal suggestion with N == C: S increments, saturating at STABLE_COUNT.
  - A legal suggestion with N != C: C <= N and S <= 1.
  - In the cycle where S reaches STABLE_COUNT, the target T <= C.
  - The filter runs every cycle, independent of FSM state.
- Let A be the current active way count (popcount of active_waymask_out). The mask is always a thermometer code.
- FSM states:
  - IDLE: T > A goes to GROW; T < A goes to SHRINK_REQ; otherwise stay in IDLE.
  - GROW: set bit A, so A increments. Return to IDLE. One way is added per visit.
  - SHRINK_REQ: flush_req_out <= 1 and flush_way_out <= A-1. Go to SHRINK_WAIT.
  - SHRINK_WAIT: hold the request until flush_ack_in is sampled high. Then clear bit A-1, drop flush_req_out, and go to IDLE.
- T is sampled only in IDLE. A target change during a flush therefore takes effect only after the current flush completes. A flush in progress is never aborted.
- flush_ack_in is ignored outside SHRINK_WAIT.
- A can never fall below 1, because a legal T is always ≥ 1.

## Timing
- Reset values:
  - active_waymask_out = 0xFFFF; A = 16 and T = 16.
  - C = 16, S = 0.
  - flush_req_out = 0, flush_way_out = 0.
  - busy_out = 0, error_out = 0.
  - FSM = IDLE.
- All outputs are registered.
- Suggestion to target: T updates on the edge that samples the STABLE_COUNT-th matching pulse. The FSM leaves IDLE on the next edge.
- Grow rate: one way per 2 cycles (IDLE, GROW).
- Shrink: flush_req_out rises 2 edges after IDLE sees T < A. When ack is high at edge k, the mask bit clears and flush_req_out falls at edge k, in the same cycle.
- A suggestion and an ack in the same cycle are both processed. The filter update is not delayed.
- Reset asserted mid-flush: flush_req_out drops immediately (asynchronously) and the mask returns to 0xFFFF. The flush engine must tolerate an abandoned request.

## Structure
- The shared package holds:
  - WAY_CNT_W = 5 (holds 0..16) and WAY_IDX_W = 4.
  - The FSM state enum {IDLE, GROW, SHRINK_REQ, SHRINK_WAIT}.
  - A popcount function and an is_thermometer function.
- One sub-module, suggestion_filter, contains:
  - the decode/legality check;
  - the C/S hysteresis;
  - outputs T and the error pulse.
- The FSM and mask register live in the top level.

## Test plan
- Reset, then pulse 0x00FF twice (STABLE_COUNT=2), with ack returned 3 cycles after each request. Required response:
  - 8 requests, for ways 15 down to 8 in order;
  - final mask 0x00FF;
  - busy_out low afterwards.
- From 0x00FF, pulse 0x0FFF twice. Required: no flush requests; mask steps through 0x01FF ... 0x0FFF at one way per 2 cycles.
- Alternate pulses 0x000F, 0x00FF, 0x000F. Required: T never changes, the mask stays 0xFFFF, and no requests are issued.
- Pulse 0x00F0, then 0x0000. Required: error_out is set and stays set; the mask is unchanged. A later legal pair 0x7FFF,0x7FFF still shrinks the mask to 0x7FFF.
- During SHRINK_WAIT for way 7, supply a stable target of 16 and assert ack. Required: way 7 is cleared, then the block regrows to 0xFFFF.
- Assert reset_n_in low while flush_req_out is high. Required: flush_req_out and busy_out are 0 immediately and the mask is 0xFFFF.

Source files
------------

// File: rtl/waymask_applier_pkg.sv
// -----------------------------------------------------------------------------
// waymask_applier_pkg
// Shared definitions for the waymask applier: way count/index widths, the
// FSM state type and the mask helper functions used by the suggestion filter.
// -----------------------------------------------------------------------------
package waymask_applier_pkg;

  localparam int NUM_WAYS  = 16;
  localparam int WAY_CNT_W = 5;  // holds 0..16
  localparam int WAY_IDX_W = 4;
  localparam int STAB_W    = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GROW        = 2'd1,
    SHRINK_REQ  = 2'd2,
    SHRINK_WAIT = 2'd3
  } applier_state_e;

  // Number of set bits in a waymask.
  function automatic logic [WAY_CNT_W-1:0] popcount(input logic [NUM_WAYS-1:0] mask);
    logic [WAY_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      cnt = cnt + {{(WAY_CNT_W-1){1'b0}}, mask[i]};
    end
    return cnt;
  endfunction

  // True for 0x0001, 0x0003, ... 0xFFFF. Adding one to a low-aligned run of
  // ones carries out of the run, so the AND with the original is zero only
  // for a thermometer code (0xFFFF wraps to zero, which still works).
  function automatic logic is_thermometer(input logic [NUM_WAYS-1:0] mask);
    logic [NUM_WAYS-1:0] plus_one;
    plus_one = mask + {{(NUM_WAYS-1){1'b0}}, 1'b1};
    return mask[0] && ((mask & plus_one) == '0);
  endfunction

endpackage

// File: rtl/waymask_applier_suggestion_filter.sv
// -----------------------------------------------------------------------------
// waymask_applier_suggestion_filter
// Decodes thermometer-coded waymask suggestions into a way count and applies
// hysteresis: a count becomes the target only after STABLE_COUNT consecutive
// legal suggestions agree. Illegal suggestions are dropped, clear the
// stability counter and raise a one-cycle error pulse.
//
// Ports
//   clk_in               clock
//   reset_n_in           asynchronous active-low reset
//   suggest_valid_in     suggestion strobe
//   suggested_waymask_in suggested waymask
//   target_cnt           accepted target way count T (registered)
//   illegal_pulse        combinational: the current strobe carries an illegal mask
// -----------------------------------------------------------------------------
module waymask_applier_suggestion_filter
  import waymask_applier_pkg::*;
#(
  parameter int STABLE_COUNT = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic                 suggest_valid_in,
  input  logic [NUM_WAYS-1:0]  suggested_waymask_in,
  output logic [WAY_CNT_W-1:0] target_cnt,
  output logic                 illegal_pulse
);

  localparam logic [STAB_W-1:0]    STABLE_LIM = STAB_W'(STABLE_COUNT);
  localparam logic [WAY_CNT_W-1:0] ALL_WAYS   = WAY_CNT_W'(NUM_WAYS);

  logic                 legal;
  logic [WAY_CNT_W-1:0] sugg_cnt;
  logic [WAY_CNT_W-1:0] cand_q, cand_d;
  logic [STAB_W-1:0]    stab_q, stab_d;
  logic                 take_target;

  always_comb begin
    legal         = is_thermometer(suggested_waymask_in);
    sugg_cnt      = popcount(suggested_waymask_in);
    cand_d        = cand_q;
    stab_d        = stab_q;
    illegal_pulse = 1'b0;
    if (suggest_valid_in) begin
      if (!legal) begin
        illegal_pulse = 1'b1;
        stab_d        = '0;
      end else if (sugg_cnt == cand_q) begin
        if (stab_q < STABLE_LIM) begin
          stab_d = stab_q + {{(STAB_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cand_d = sugg_cnt;
        stab_d = {{(STAB_W-1){1'b0}}, 1'b1};
      end
    end
    // Re-arming T while already saturated rewrites the same value, which keeps
    // the condition simple and also covers STABLE_COUNT == 1.
    take_target = suggest_valid_in && legal && (stab_d == STABLE_LIM);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cand_q     <= ALL_WAYS;
      stab_q     <= '0;
      target_cnt <= ALL_WAYS;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
      if (take_target) begin
        target_cnt <= cand_d;
      end
    end
  end

endmodule

// File: rtl/waymask_applier.sv
// -----------------------------------------------------------------------------
// waymask_applier
// Walks the cache's active waymask toward the filtered target one way at a
// time. Ways are added directly; before a way is removed it is handed to the
// flush engine and the mask bit is cleared only after the flush completes.
//
// Ports
//   clk_in               clock
//   reset_n_in           asynchronous active-low reset
//   suggest_valid_in     suggestion strobe
//   suggested_waymask_in suggested thermometer waymask
//   flush_ack_in         flush engine finished cleaning flush_way_out
//   flush_req_out        request to flush one way
//   flush_way_out        way being flushed, stable while flush_req_out is high
//   active_waymask_out   waymask applied to cache allocation (thermometer)
//   busy_out             FSM not in IDLE
//   error_out            sticky: an illegal suggestion was seen
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | compare target T with active count A, pick a direction
// GROW        | add way A to the mask, return to IDLE
// SHRINK_REQ  | raise flush request for way A-1
// SHRINK_WAIT | hold request until ack, then clear way A-1 and return to IDLE
// -----------------------------------------------------------------------------
module waymask_applier
  import waymask_applier_pkg::*;
#(
  parameter int CACHE_ASSOCIATIVITY = 16,
  parameter int STABLE_COUNT        = 2
) (
  input  logic                           clk_in,
  input  logic                           reset_n_in,
  input  logic                           suggest_valid_in,
  input  logic [CACHE_ASSOCIATIVITY-1:0] suggested_waymask_in,
  input  logic                           flush_ack_in,
  output logic                           flush_req_out,
  output logic [WAY_IDX_W-1:0]           flush_way_out,
  output logic [CACHE_ASSOCIATIVITY-1:0] active_waymask_out,
  output logic                           busy_out,
  output logic                           error_out
);

  localparam logic [WAY_CNT_W-1:0] ALL_WAYS = WAY_CNT_W'(NUM_WAYS);
  localparam logic [WAY_CNT_W-1:0] ONE_WAY  = WAY_CNT_W'(1);

  applier_state_e       state_q, state_d;
  logic [WAY_CNT_W-1:0] active_cnt_q;
  logic [WAY_CNT_W-1:0] target_cnt;
  logic                 illegal_pulse;

  waymask_applier_suggestion_filter #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_suggestion_filter (
    .clk_in               (clk_in),
    .reset_n_in           (reset_n_in),
    .suggest_valid_in     (suggest_valid_in),
    .suggested_waymask_in (suggested_waymask_in),
    .target_cnt           (target_cnt),
    .illegal_pulse        (illegal_pulse)
  );

  // T is only consulted in IDLE, so a retarget during a flush waits for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (target_cnt > active_cnt_q) begin
          state_d = GROW;
        end else if (target_cnt < active_cnt_q) begin
          state_d = SHRINK_REQ;
        end
      end
      GROW:        state_d = IDLE;
      SHRINK_REQ:  state_d = SHRINK_WAIT;
      SHRINK_WAIT: if (flush_ack_in) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q            <= IDLE;
      active_waymask_out <= '1;
      active_cnt_q       <= ALL_WAYS;
      flush_req_out      <= 1'b0;
      flush_way_out      <= '0;
      busy_out           <= 1'b0;
      error_out          <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_out  <= (state_d != IDLE);
      error_out <= error_out | illegal_pulse;
      case (state_q)
        GROW: begin
          active_waymask_out <= {active_waymask_out[CACHE_ASSOCIATIVITY-2:0], 1'b1};
          active_cnt_q       <= active_cnt_q + ONE_WAY;
        end
        SHRINK_REQ: begin
          // A is 1..16, so the low four bits minus one wrap 16 -> 15 correctly.
          flush_req_out <= 1'b1;
          flush_way_out <= active_cnt_q[WAY_IDX_W-1:0] - {{(WAY_IDX_W-1){1'b0}}, 1'b1};
        end
        SHRINK_WAIT: begin
          if (flush_ack_in) begin
            active_waymask_out <= {1'b0, active_waymask_out[CACHE_ASSOCIATIVITY-1:1]};
            active_cnt_q       <= active_cnt_q - ONE_WAY;
            flush_req_out      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_waymask_applier.sv
module tb_waymask_applier;

  localparam int STABLE = 2;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        suggest_valid_in;
  logic [15:0] suggested_waymask_in;
  logic        engine_ack;
  logic        manual_ack;
  logic        flush_ack_in;
  logic        flush_req_out;
  logic [3:0]  flush_way_out;
  logic [15:0] active_waymask_out;
  logic        busy_out;
  logic        error_out;

  assign flush_ack_in = engine_ack | manual_ack;

  always #5 clk_in = ~clk_in;

  waymask_applier #(
    .CACHE_ASSOCIATIVITY (16),
    .STABLE_COUNT        (STABLE)
  ) dut (
    .clk_in               (clk_in),
    .reset_n_in           (reset_n_in),
    .suggest_valid_in     (suggest_valid_in),
    .suggested_waymask_in (suggested_waymask_in),
    .flush_ack_in         (flush_ack_in),
    .flush_req_out        (flush_req_out),
    .flush_way_out        (flush_way_out),
    .active_waymask_out   (active_waymask_out),
    .busy_out             (busy_out),
    .error_out            (error_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the suggestion filter (candidate, stability, target, error).
  int m_c, m_s, m_t;
  bit m_err;

  // Flush engine model: logs each new request, acks after ack_delay cycles.
  logic [3:0] flush_log[$];
  bit         engine_auto = 1'b1;
  int         ack_delay   = 3;

  function automatic int legal_count(input logic [15:0] m);
    for (int n = 1; n <= 16; n++) begin
      if ({16'd0, m} == ((32'd1 << n) - 32'd1)) return n;
    end
    return 0;
  endfunction

  function automatic logic [15:0] thermo(input int n);
    logic [31:0] t;
    t = (32'd1 << n) - 32'd1;
    return t[15:0];
  endfunction

  task automatic model_reset();
    m_c = 16; m_s = 0; m_t = 16; m_err = 1'b0;
  endtask

  task automatic model_pulse(input logic [15:0] m);
    int n;
    n = legal_count(m);
    if (n == 0) begin
      m_err = 1'b1;
      m_s   = 0;
    end else begin
      if (n == m_c) begin
        if (m_s < STABLE) m_s++;
      end else begin
        m_c = n;
        m_s = 1;
      end
      if (m_s == STABLE) m_t = m_c;
    end
  endtask

  initial begin
    int         age;
    logic [3:0] cur_way;
    engine_ack = 1'b0;
    age        = 0;
    cur_way    = '0;
    forever begin
      @(posedge clk_in);
      #2;
      if (flush_req_out === 1'b1) begin
        if (age == 0) begin
          flush_log.push_back(flush_way_out);
          cur_way = flush_way_out;
        end else begin
          checks++;
          if (flush_way_out !== cur_way) begin
            errors++;
            $display("FAIL way_stable: flush_way_out=%0d while request held, required %0d", flush_way_out, cur_way);
          end
        end
        age++;
        engine_ack = engine_auto && (age == ack_delay);
      end else begin
        age        = 0;
        engine_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input logic [15:0] m);
    suggest_valid_in     = 1'b1;
    suggested_waymask_in = m;
    model_pulse(m);
    tick();
    suggest_valid_in     = 1'b0;
    suggested_waymask_in = '0;
  endtask

  task automatic do_reset();
    reset_n_in           = 1'b0;
    suggest_valid_in     = 1'b0;
    suggested_waymask_in = '0;
    manual_ack           = 1'b0;
    repeat (2) tick();
    reset_n_in = 1'b1;
    tick();
    model_reset();
    flush_log.delete();
  endtask

  task automatic wait_settle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 600) begin
      tick();
      n++;
      if (!busy_out && !flush_req_out) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s_settle: still busy after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (flush_req_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (flush_req_out !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: flush_req_out=%b after %0d cycles, required 1", tag, flush_req_out, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (active_waymask_out !== 16'hFFFF) begin errors++; $display("FAIL reset_mask: got %h, required ffff", active_waymask_out); end
    if (flush_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", flush_req_out); end
    if (flush_way_out !== 4'd0) begin errors++; $display("FAIL reset_way: got %0d, required 0", flush_way_out); end
    if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_out); end
    if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", error_out); end
  endtask

  task automatic test_shrink();
    engine_auto = 1'b1;
    ack_delay   = 3;
    flush_log.delete();
    pulse(16'h00FF);
    pulse(16'h00FF);
    tick();
    checks += 2;
    if (flush_req_out !== 1'b0) begin errors++; $display("FAIL shrink_req_early: got %b one edge after target, required 0", flush_req_out); end
    if (busy_out !== 1'b1) begin errors++; $display("FAIL shrink_busy: got %b, required 1", busy_out); end
    tick();
    checks += 2;
    if (flush_req_out !== 1'b1) begin errors++; $display("FAIL shrink_req_rise: got %b two edges after target, required 1", flush_req_out); end
    if (flush_way_out !== 4'd15) begin errors++; $display("FAIL shrink_first_way: got %0d, required 15", flush_way_out); end
    wait_settle("shrink");
    checks++;
    if (flush_log.size() != 8) begin
      errors++;
      $display("FAIL shrink_count: got %0d requests, required 8", flush_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (flush_log[i] !== 4'(15 - i)) begin errors++; $display("FAIL shrink_order[%0d]: got way %0d, required %0d", i, flush_log[i], 15 - i); end
      end
    end
    checks += 3;
    if (active_waymask_out !== thermo(m_t)) begin errors++; $display("FAIL shrink_mask: got %h, required %h", active_waymask_out, thermo(m_t)); end
    if (active_waymask_out !== 16'h00FF) begin errors++; $display("FAIL shrink_mask_const: got %h, required 00ff", active_waymask_out); end
    if (busy_out !== 1'b0) begin errors++; $display("FAIL shrink_busy_end: got %b, required 0", busy_out); end
  endtask

  task automatic test_grow();
    flush_log.delete();
    pulse(16'h0FFF);
    pulse(16'h0FFF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (active_waymask_out !== thermo(7 + k)) begin errors++; $display("FAIL grow_hold[%0d]: got %h, required %h", k, active_waymask_out, thermo(7 + k)); end
      tick();
      checks += 2;
      if (active_waymask_out !== thermo(8 + k)) begin errors++; $display("FAIL grow_step[%0d]: got %h, required %h", k, active_waymask_out, thermo(8 + k)); end
      if (flush_req_out !== 1'b0) begin errors++; $display("FAIL grow_req[%0d]: got %b, required 0", k, flush_req_out); end
    end
    wait_settle("grow");
    checks += 2;
    if (active_waymask_out !== thermo(m_t)) begin errors++; $display("FAIL grow_mask: got %h, required %h", active_waymask_out, thermo(m_t)); end
    if (flush_log.size() != 0) begin errors++; $display("FAIL grow_no_flush: got %0d requests, required 0", flush_log.size()); end
  endtask

  task automatic test_alternate();
    logic [15:0] seq [3];
    seq[0] = 16'h000F; seq[1] = 16'h00FF; seq[2] = 16'h000F;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(seq[i]);
      for (int j = 0; j < 4; j++) begin
        tick();
        checks += 2;
        if (flush_req_out !== 1'b0) begin errors++; $display("FAIL alt_req[%0d]: got %b, required 0", i, flush_req_out); end
        if (active_waymask_out !== thermo(m_t)) begin errors++; $display("FAIL alt_mask[%0d]: got %h, required %h", i, active_waymask_out, thermo(m_t)); end
      end
    end
    checks += 3;
    if (active_waymask_out !== 16'hFFFF) begin errors++; $display("FAIL alt_mask_end: got %h, required ffff", active_waymask_out); end
    if (flush_log.size() != 0) begin errors++; $display("FAIL alt_no_flush: got %0d requests, required 0", flush_log.size()); end
    if (busy_out !== 1'b0) begin errors++; $display("FAIL alt_busy: got %b, required 0", busy_out); end
  endtask

  task automatic test_illegal();
    flush_log.delete();
    pulse(16'h00F0);
    checks++;
    if (error_out !== m_err) begin errors++; $display("FAIL illegal_err_set: got %b, required %b", error_out, m_err); end
    pulse(16'h0000);
    repeat (3) tick();
    checks += 2;
    if (error_out !== 1'b1) begin errors++; $display("FAIL illegal_err_sticky: got %b, required 1", error_out); end
    if (active_waymask_out !== 16'hFFFF) begin errors++; $display("FAIL illegal_mask: got %h, required ffff", active_waymask_out); end
    pulse(16'h7FFF);
    pulse(16'h7FFF);
    wait_settle("illegal");
    checks += 3;
    if (active_waymask_out !== thermo(m_t)) begin errors++; $display("FAIL illegal_recover_mask: got %h, required %h", active_waymask_out, thermo(m_t)); end
    if (flush_log.size() != 1 || flush_log[0] !== 4'd15) begin errors++; $display("FAIL illegal_recover_flush: got %0d requests, required one for way 15", flush_log.size()); end
    if (error_out !== 1'b1) begin errors++; $display("FAIL illegal_err_kept: got %b, required 1", error_out); end
  endtask

  task automatic test_retarget_during_flush();
    do_reset();
    engine_auto = 1'b1;
    ack_delay   = 2;
    pulse(16'h00FF);
    pulse(16'h00FF);
    wait_settle("retarget_setup");
    flush_log.delete();
    engine_auto = 1'b0;
    pulse(16'h007F);
    pulse(16'h007F);
    wait_req("retarget");
    checks++;
    if (flush_way_out !== 4'd7) begin errors++; $display("FAIL retarget_way: got %0d, required 7", flush_way_out); end
    repeat (3) tick();
    checks += 2;
    if (flush_req_out !== 1'b1) begin errors++; $display("FAIL retarget_hold: got %b, required 1", flush_req_out); end
    if (active_waymask_out !== 16'h00FF) begin errors++; $display("FAIL retarget_mask_hold: got %h, required 00ff", active_waymask_out); end
    pulse(16'hFFFF);
    // Second matching suggestion and the ack land on the same edge.
    suggest_valid_in     = 1'b1;
    suggested_waymask_in = 16'hFFFF;
    manual_ack           = 1'b1;
    model_pulse(16'hFFFF);
    tick();
    suggest_valid_in     = 1'b0;
    suggested_waymask_in = '0;
    manual_ack           = 1'b0;
    checks += 2;
    if (flush_req_out !== 1'b0) begin errors++; $display("FAIL retarget_req_drop: got %b, required 0", flush_req_out); end
    if (active_waymask_out !== 16'h007F) begin errors++; $display("FAIL retarget_cleared: got %h, required 007f", active_waymask_out); end
    engine_auto = 1'b1;
    wait_settle("retarget");
    checks += 2;
    if (active_waymask_out !== thermo(m_t)) begin errors++; $display("FAIL retarget_regrow: got %h, required %h", active_waymask_out, thermo(m_t)); end
    if (flush_log.size() != 1) begin errors++; $display("FAIL retarget_flushes: got %0d requests, required 1", flush_log.size()); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    engine_auto = 1'b0;
    pulse(16'h7FFF);
    pulse(16'h7FFF);
    wait_req("midreset");
    tick();
    reset_n_in = 1'b0;
    #1;
    checks += 3;
    if (flush_req_out !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b, required 0", flush_req_out); end
    if (busy_out !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy_out); end
    if (active_waymask_out !== 16'hFFFF) begin errors++; $display("FAIL midreset_mask: got %h, required ffff", active_waymask_out); end
    tick();
    reset_n_in = 1'b1;
    tick();
    model_reset();
    flush_log.delete();
    engine_auto = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    engine_auto = 1'b1;
    for (int step = 0; step < 25; step++) begin
      int a_prev, nn, tgt, exp_n;
      a_prev    = m_t;
      ack_delay = $urandom_range(4, 1);
      flush_log.delete();
      nn = $urandom_range(3, 0);
      for (int j = 0; j < nn; j++) begin
        logic [15:0] cand;
        int sc, ss, st;
        bit se;
        if ($urandom_range(9, 0) < 6) cand = thermo($urandom_range(16, 1));
        else cand = 16'($urandom);
        sc = m_c; ss = m_s; st = m_t; se = m_err;
        model_pulse(cand);
        if (m_t == st) begin
          m_c = sc; m_s = ss; m_t = st; m_err = se;
          pulse(cand);
          repeat ($urandom_range(2, 0)) tick();
        end else begin
          m_c = sc; m_s = ss; m_t = st; m_err = se;
        end
      end
      tgt = $urandom_range(16, 1);
      for (int j = 0; j < STABLE; j++) begin
        pulse(thermo(tgt));
        repeat ($urandom_range(2, 0)) tick();
      end
      wait_settle("random");
      exp_n = (a_prev > m_t) ? a_prev - m_t : 0;
      checks += 4;
      if (active_waymask_out !== thermo(m_t)) begin errors++; $display("FAIL random_mask[%0d]: got %h, required %h", step, active_waymask_out, thermo(m_t)); end
      if (error_out !== m_err) begin errors++; $display("FAIL random_err[%0d]: got %b, required %b", step, error_out, m_err); end
      if (busy_out !== 1'b0) begin errors++; $display("FAIL random_busy[%0d]: got %b, required 0", step, busy_out); end
      if (flush_log.size() != exp_n) begin
        errors++;
        $display("FAIL random_flush_count[%0d]: got %0d, required %0d", step, flush_log.size(), exp_n);
      end else begin
        for (int i = 0; i < exp_n; i++) begin
          checks++;
          if (flush_log[i] !== 4'(a_prev - 1 - i)) begin errors++; $display("FAIL random_flush_way[%0d.%0d]: got %0d, required %0d", step, i, flush_log[i], a_prev - 1 - i); end
        end
      end
    end
  endtask

  initial begin
    reset_n_in           = 1'b0;
    suggest_valid_in     = 1'b0;
    suggested_waymask_in = '0;
    manual_ack           = 1'b0;
    model_reset();
    test_reset();
    test_shrink();
    test_grow();
    test_alternate();
    test_illegal();
    test_retarget_during_flush();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
